// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: runs a fixed-latency busy window per
// MULT/MULTU/DIV/DIVU job, owns HI/LO and raises the D-stage MD stall request.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  md_op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        d_md_use_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic          is_signed;
    logic [63:0]   a_ext, b_ext, prod;
    logic          a_neg, b_neg, div_by_zero;
    logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    // op_q[1] selects divide, op_q[0] selects the unsigned variant.
    always_comb begin
        is_signed   = ~op_q[0];
        a_ext       = {{32{is_signed & a_q[31]}}, a_q};
        b_ext       = {{32{is_signed & b_q[31]}}, b_q};
        prod        = a_ext * b_ext;

        a_neg       = is_signed & a_q[31];
        b_neg       = is_signed & b_q[31];
        a_mag       = a_neg ? (32'd0 - a_q) : a_q;
        b_mag       = b_neg ? (32'd0 - b_q) : b_q;
        div_by_zero = (b_q == 32'd0);
        b_safe      = div_by_zero ? 32'd1 : b_mag;
        q_mag       = a_mag / b_safe;
        r_mag       = a_mag % b_safe;
        // Magnitude division handles 0x80000000 / -1 naturally: quotient wraps back to 0x80000000.
        quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem         = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (!md_op_i[2]) begin
                        a_d     = rs_i;
                        b_d     = rt_i;
                        op_d    = md_op_i[1:0];
                        cnt_d   = md_op_i[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_d = RUN;
                    end else if (md_op_i == 3'd4) begin
                        hi_d = rs_i;
                    end else if (md_op_i == 3'd5) begin
                        lo_d = rs_i;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!div_by_zero) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o  = (state_q == RUN);
    // Start term covers an MFHI/MFLO in D directly behind a job entering E this cycle.
    assign stall_o = d_md_use_i & (busy_o | (start_i & ~md_op_i[2]));
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: per-cycle comparison against a job-level model plus
// directed jobs with hand-computed HI/LO and busy-window lengths.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs, rt;
    logic        d_use;
    logic        busy_o, stall_o;
    logic [31:0] hi_o, lo_o;

    int errors = 0;
    int checks = 0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .md_op_i(md_op),
        .rs_i(rs), .rt_i(rt), .d_md_use_i(d_use),
        .busy_o(busy_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: result computed at start from the arithmetic rules, applied after N cycles.
    function automatic logic [64:0] model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        int              sa, sb;
        logic [31:0]     h, l;
        logic            wr;
        wr = 1'b1; h = '0; l = '0;
        sa = a; sb = b;
        case (op)
            3'd0: begin ps = longint'($signed(a)) * longint'($signed(b)); {h, l} = ps; end
            3'd1: begin pu = {32'd0, a} * {32'd0, b}; {h, l} = pu; end
            3'd2: begin
                if (b == 32'd0) wr = 1'b0;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = a; h = 32'd0; end
                else begin l = sa / sb; h = sa % sb; end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin l = a / b; h = a % b; end
            end
        endcase
        return {wr, h, l};
    endfunction

    int          m_left;
    logic [31:0] m_hi, m_lo, m_nhi, m_nlo;
    logic        m_wr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_hi <= '0; m_lo <= '0; m_wr <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_wr) begin
                m_hi <= m_nhi;
                m_lo <= m_nlo;
            end
        end else if (start) begin
            if (md_op <= 3'd3) begin
                {m_wr, m_nhi, m_nlo} <= model_op(md_op, rs, rt);
                m_left <= (md_op >= 3'd2) ? DC : MC;
            end else if (md_op == 3'd4) begin
                m_hi <= rs;
            end else if (md_op == 3'd5) begin
                m_lo <= rs;
            end
        end
    end

    always @(negedge clk) begin
        logic eb;
        eb = (m_left > 0);
        chk("busy", {31'd0, busy_o}, {31'd0, eb});
        chk("stall", {31'd0, stall_o}, {31'd0, d_use & (eb | (start & (md_op <= 3'd3)))});
        chk("hi", hi_o, m_hi);
        chk("lo", lo_o, m_lo);
        if (rst_n && start && eb) begin
            errors++;
            $display("FAIL protocol: start issued while busy at %0t", $time);
        end
    end

    task automatic do_job(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, output int nbusy);
        @(posedge clk); #1;
        start = 1'b1; md_op = op; rs = a; rt = b; d_use = use_d;
        if (use_d) begin
            @(negedge clk);
            chk("stall_start_cycle", {31'd0, stall_o}, 32'd1);
        end
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7; rs = $urandom; rt = $urandom;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            nbusy++;
        end
        if (use_d) chk("stall_after_busy", {31'd0, stall_o}, 32'd0);
        d_use = 1'b0;
        $display("job op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", op, a, b, nbusy, hi_o, lo_o);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        start = 1'b1; md_op = op; rs = v;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7;
        @(negedge clk);
        chk("mt_busy", {31'd0, busy_o}, 32'd0);
        $display("mt op=%0d v=%08h hi=%08h lo=%08h", op, v, hi_o, lo_o);
    endtask

    initial begin
        int nb;
        rst_n = 1'b0; start = 1'b0; md_op = 3'd7; rs = '0; rt = '0; d_use = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        do_job(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, nb);
        chk("multu_busy", nb, 5);
        chk("multu_hi", hi_o, 32'hFFFFFFFE);
        chk("multu_lo", lo_o, 32'h00000001);

        do_job(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, nb);
        chk("mult_busy", nb, 5);
        chk("mult_hi", hi_o, 32'hFFFFFFFF);
        chk("mult_lo", lo_o, 32'hFFFFFFFA);

        do_job(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, nb);
        chk("div_busy", nb, 10);
        chk("div_lo", lo_o, 32'hFFFFFFFD);
        chk("div_hi", hi_o, 32'hFFFFFFFF);

        mt(3'd4, 32'h11);
        mt(3'd5, 32'h22);
        do_job(3'd3, 32'd100, 32'd0, 1'b0, nb);
        chk("divz_busy", nb, 10);
        chk("divz_hi", hi_o, 32'h11);
        chk("divz_lo", lo_o, 32'h22);

        do_job(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, nb);
        chk("divovf_lo", lo_o, 32'h80000000);
        chk("divovf_hi", hi_o, 32'h0);

        do_job(3'd3, 32'd100, 32'd7, 1'b0, nb);
        chk("divu_lo", lo_o, 32'd14);
        chk("divu_hi", hi_o, 32'd2);

        do_job(3'd0, 32'd7, 32'hFFFFFFFA, 1'b1, nb);
        chk("stall_mult_busy", nb, 5);
        chk("stall_mult_lo", lo_o, 32'hFFFFFFD6);
        chk("stall_mult_hi", hi_o, 32'hFFFFFFFF);

        @(posedge clk); #1;
        start = 1'b1; md_op = 3'd6; rs = 32'h1234; rt = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7;
        @(negedge clk);
        chk("noop_busy", {31'd0, busy_o}, 32'd0);
        chk("noop_lo", lo_o, 32'hFFFFFFD6);

        // Abort a DIV in its fourth busy cycle.
        @(posedge clk); #1;
        start = 1'b1; md_op = 3'd2; rs = 32'd1000; rt = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7;
        nb = 0;
        for (int i = 0; i < 20 && nb < 4; i++) begin
            @(negedge clk);
            if (busy_o) nb++;
        end
        chk("abort_reached", nb, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_hi", hi_o, 32'd0);
        chk("abort_lo", lo_o, 32'd0);
        $display("reset mid-DIV busy=%0d hi=%08h lo=%08h", busy_o, hi_o, lo_o);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        mt(3'd4, 32'hDEADBEEF);
        chk("mthi_hi", hi_o, 32'hDEADBEEF);
        chk("mthi_busy", {31'd0, busy_o}, 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
